usb_fs_tx: RTL and testbench

- Full-speed USB serial transmitter: the transmit counterpart of the device receiver path. It turns a byte stream into SYNC, NRZI-encoded bit-stuffed data and EOP on the tx_j/tx_se0/tx_en pad controls.
- Sits between the packet/PID layer and the pad muxes: usb_dp = tx_en ? (tx_se0 ? 0 : tx_j) : z, and usb_dn correspondingly.
- Runs from the 48 MHz USB clock at 4 clocks per bit (12 Mb/s).

---
 rtl/usb_fs_tx_if.sv | 41 ++++
 rtl/usb_fs_tx.sv | 165 ++++++++++++++++
 tb/tb_usb_fs_tx.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/usb_fs_tx_if.sv
// usb_fs_tx_if: byte handshake and pad-control bundle for the full-speed USB transmitter.
// The packet layer owns the master side and the transmitter owns the slave side.
// Optional macro USB_TX_ABORT_EN adds the tx_abort request line.
interface usb_fs_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
`ifdef USB_TX_ABORT_EN
    logic       tx_abort;
`endif
    logic       tx_strobe;
    logic       tx_busy;
    logic       tx_en;
    logic       tx_j;
    logic       tx_se0;

    modport master (
        output tx_valid,
        output tx_data,
`ifdef USB_TX_ABORT_EN
        output tx_abort,
`endif
        input  tx_strobe,
        input  tx_busy,
        input  tx_en,
        input  tx_j,
        input  tx_se0
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
`ifdef USB_TX_ABORT_EN
        input  tx_abort,
`endif
        output tx_strobe,
        output tx_busy,
        output tx_en,
        output tx_j,
        output tx_se0
    );
endinterface

// File: rtl/usb_fs_tx.sv
// usb_fs_tx: full-speed USB serial transmitter.
// Sends SYNC, NRZI-encoded bit-stuffed data bytes and EOP on the pad controls,
// one USB bit every CLKS_PER_BIT cycles of the 48 MHz clock.
// Bytes are fetched from the interface while the 8th bit of SYNC or of the current
// byte goes out, so the next byte follows with no gap.
// Optional macro USB_TX_ABORT_EN: tx_abort ends the packet with a run of 7 ones
// (a deliberate stuff error) followed by a normal EOP.
module usb_fs_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk_48,
    input  logic       rst_n,
    usb_fs_tx_if.slave bus
);
    localparam int PW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] PHASE_ONE  = PW'(1);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        EOP_SE0,
        EOP_J
`ifdef USB_TX_ABORT_EN
        , ABORT
`endif
    } state_t;

    state_t        state_q;
    logic [PW-1:0] phase_q;
    logic [7:0]    hold_q;
    logic [2:0]    bitIdx_q;
    logic [2:0]    ones_q;
    logic          last_q;
    logic          txEn_q;
    logic          txJ_q;
    logic          txSe0_q;
    logic          txStrobe_q;
    logic          txBusy_q;

    logic          bitEnd;
    logic          curBit;

    assign bitEnd = (phase_q == PHASE_LAST);
    assign curBit = hold_q[bitIdx_q];

    assign bus.tx_en     = txEn_q;
    assign bus.tx_j      = txJ_q;
    assign bus.tx_se0    = txSe0_q;
    assign bus.tx_strobe = txStrobe_q;
    assign bus.tx_busy   = txBusy_q;

    // Packet sequencer: bit timer, NRZI/stuffing encoder, byte fetch and EOP, all registered.
    always_ff @(posedge clk_48) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            phase_q    <= '0;
            hold_q     <= '0;
            bitIdx_q   <= '0;
            ones_q     <= '0;
            last_q     <= 1'b0;
            txEn_q     <= 1'b0;
            txJ_q      <= 1'b1;
            txSe0_q    <= 1'b0;
            txStrobe_q <= 1'b0;
            txBusy_q   <= 1'b0;
        end else begin
            txStrobe_q <= 1'b0;
            if (state_q != IDLE) begin
                phase_q <= bitEnd ? '0 : phase_q + PHASE_ONE;
            end
            case (state_q)
                IDLE: begin
                    if (bus.tx_valid) begin
                        // First SYNC bit (a 0) is launched right away: J toggles to K.
                        state_q  <= SYNC;
                        phase_q  <= '0;
                        txEn_q   <= 1'b1;
                        txBusy_q <= 1'b1;
                        txJ_q    <= 1'b0;
                        txSe0_q  <= 1'b0;
                        hold_q   <= 8'h80;
                        bitIdx_q <= 3'd1;
                        ones_q   <= '0;
                        last_q   <= 1'b0;
                    end
                end
                SYNC, DATA: begin
`ifdef USB_TX_ABORT_EN
                    if (bus.tx_abort) begin
                        state_q  <= ABORT;
                        phase_q  <= '0;
                        bitIdx_q <= '0;
                    end else
`endif
                    if (bitEnd) begin
                        if (ones_q == 3'd6) begin
                            // Stuffed zero: toggle, clear the run, keep the data index.
                            txJ_q  <= ~txJ_q;
                            ones_q <= '0;
                        end else if (last_q) begin
                            state_q  <= EOP_SE0;
                            txSe0_q  <= 1'b1;
                            bitIdx_q <= '0;
                        end else begin
                            if (curBit) begin
                                ones_q <= ones_q + 3'd1;
                            end else begin
                                txJ_q  <= ~txJ_q;
                                ones_q <= '0;
                            end
                            bitIdx_q <= bitIdx_q + 3'd1;
                            if (bitIdx_q == 3'd7) begin
                                // Bit 7 is on its way out, so the holding register is free.
                                state_q <= DATA;
                                if (bus.tx_valid) begin
                                    hold_q     <= bus.tx_data;
                                    txStrobe_q <= 1'b1;
                                end else begin
                                    last_q <= 1'b1;
                                end
                            end
                        end
                    end
                end
`ifdef USB_TX_ABORT_EN
                ABORT: begin
                    if (bitEnd) begin
                        if (bitIdx_q == 3'd6) begin
                            state_q  <= EOP_SE0;
                            txSe0_q  <= 1'b1;
                            bitIdx_q <= '0;
                        end else begin
                            bitIdx_q <= bitIdx_q + 3'd1;
                        end
                    end
                end
`endif
                EOP_SE0: begin
                    if (bitEnd) begin
                        if (bitIdx_q == 3'd0) begin
                            bitIdx_q <= 3'd1;
                        end else begin
                            state_q <= EOP_J;
                            txSe0_q <= 1'b0;
                            txJ_q   <= 1'b1;
                        end
                    end
                end
                EOP_J: begin
                    if (bitEnd) begin
                        state_q  <= IDLE;
                        txEn_q   <= 1'b0;
                        txBusy_q <= 1'b0;
                        txJ_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_usb_fs_tx.sv
// tb_usb_fs_tx: self-checking bench for usb_fs_tx.
// A line monitor rebuilds each packet from the pads, NRZI-decodes and de-stuffs it,
// and compares it with the expected packet queued when the stimulus was driven.
module tb_usb_fs_tx;
    localparam int CPB = 4;
    localparam logic [1:0] SYM_K   = 2'd0;
    localparam logic [1:0] SYM_J   = 2'd1;
    localparam logic [1:0] SYM_SE0 = 2'd2;

    typedef struct packed {
        logic [2:0]  nBytes;
        logic [31:0] bytes;
        logic [9:0]  expEnClocks;
        logic [2:0]  expStrobes;
    } vec_t;

    logic clk_48 = 1'b0;
    logic rst_n  = 1'b0;

    usb_fs_tx_if txIf ();

    usb_fs_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk_48 (clk_48),
        .rst_n  (rst_n),
        .bus    (txIf)
    );

    always #5 clk_48 = ~clk_48;

    int   checks = 0;
    int   failures = 0;
    vec_t sbQ [$];
    vec_t vecs [6];

    // Monitor state for the most recent packet.
    bit         monEnable = 0;
    bit         ignoreNext = 0;
    bit         inPkt = 0;
    int         cyc = 0;
    int         nSym = 0;
    int         nStrobe = 0;
    int         unstable = 0;
    int         busyOff = 0;
    int         enClocks = 0;
    int         pktCount = 0;
    int         strayStrobe = 0;
    logic [1:0] prevSym = SYM_J;
    logic [1:0] syms [64];
    int         strobeCyc [8];

    // Decoder results.
    logic [7:0] decByte [8];
    int         nDec = 0;
    int         stuffErr = 0;
    int         eopOk = 0;
    logic [7:0] syncByte = '0;

    function automatic void checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    function automatic void decodePacket();
        int prev;
        int ones;
        int nbits;
        int b;
        int i;
        bit skip;
        logic [7:0] sh;
        prev = int'(SYM_J);
        ones = 0;
        nbits = 0;
        skip = 0;
        sh = '0;
        nDec = 0;
        stuffErr = 0;
        eopOk = 0;
        syncByte = '0;
        i = 0;
        while (i < nSym && i < 64 && syms[i] != SYM_SE0) begin
            b = (int'(syms[i]) == prev) ? 1 : 0;
            prev = int'(syms[i]);
            if (skip) begin
                skip = 0;
                if (b != 0) stuffErr++;
            end else begin
                sh = {b[0], sh[7:1]};
                nbits++;
                ones = (b != 0) ? ones + 1 : 0;
                if (ones == 6) begin
                    skip = 1;
                    ones = 0;
                end
                if (nbits % 8 == 0) begin
                    if (nbits == 8) syncByte = sh;
                    else begin
                        if (nDec < 8) decByte[nDec] = sh;
                        nDec++;
                    end
                end
            end
            i++;
        end
        if (skip) stuffErr++;
        if (nbits % 8 != 0) stuffErr++;
        if ((i + 3 == nSym) && (i + 2 < 64))
            eopOk = (syms[i] == SYM_SE0 && syms[i+1] == SYM_SE0 && syms[i+2] == SYM_J) ? 1 : 0;
    endfunction

    function automatic void checkPacket(input vec_t e);
        decodePacket();
        checkOutput("en_clocks", enClocks, int'(e.expEnClocks));
        checkOutput("strobe_count", nStrobe, int'(e.expStrobes));
        checkOutput("line_stable_in_bit", unstable, 0);
        checkOutput("busy_tracks_en", busyOff, 0);
        checkOutput("sync_byte", int'(syncByte), 8'h80);
        checkOutput("stuff_errors", stuffErr, 0);
        checkOutput("eop_se0_se0_j", eopOk, 1);
        checkOutput("byte_count", nDec, int'(e.nBytes));
        for (int i = 0; i < nDec && i < int'(e.nBytes); i++)
            checkOutput("data_byte", int'(decByte[i]), int'(e.bytes[i*8 +: 8]));
    endfunction

    // Line monitor: samples pads mid-cycle, one symbol per bit, and scores finished packets.
    always @(negedge clk_48) begin
        logic [1:0] s;
        vec_t e;
        if (monEnable) begin
            s = txIf.tx_se0 ? SYM_SE0 : (txIf.tx_j ? SYM_J : SYM_K);
            if (txIf.tx_en) begin
                if (!inPkt) begin
                    inPkt = 1;
                    cyc = 0;
                    nSym = 0;
                    nStrobe = 0;
                    unstable = 0;
                    busyOff = 0;
                end
                if (cyc % CPB == 1) begin
                    if (nSym < 64) syms[nSym] = s;
                    nSym++;
                end
                if (cyc % CPB != 0 && s != prevSym) unstable++;
                if (!txIf.tx_busy) busyOff++;
                if (txIf.tx_strobe) begin
                    if (nStrobe < 8) strobeCyc[nStrobe] = cyc;
                    nStrobe++;
                end
                prevSym = s;
                cyc++;
            end else begin
                if (txIf.tx_strobe) strayStrobe++;
                if (txIf.tx_busy) busyOff++;
                if (inPkt) begin
                    inPkt = 0;
                    enClocks = cyc;
                    if (ignoreNext) ignoreNext = 0;
                    else if (sbQ.size() == 0) checkOutput("unexpected_packet", 1, 0);
                    else begin
                        e = sbQ.pop_front();
                        checkPacket(e);
                    end
                    pktCount++;
                end
            end
        end
    end

    task automatic waitStrobe(input string name);
        int t;
        t = 0;
        do begin
            @(negedge clk_48);
            t++;
        end while (!txIf.tx_strobe && t < 200);
        if (!txIf.tx_strobe) checkOutput(name, 0, 1);
    endtask

    task automatic waitPacketEnd(input int startCount);
        int t;
        t = 0;
        while (pktCount == startCount && t < 2000) begin
            @(negedge clk_48);
            t++;
        end
        if (pktCount == startCount) checkOutput("packet_end_timeout", 0, 1);
    endtask

    task automatic applyStimulus(input vec_t v);
        int sent;
        int t;
        int startCount;
        sbQ.push_back(v);
        startCount = pktCount;
        @(negedge clk_48);
        txIf.tx_valid = 1'b1;
        txIf.tx_data  = v.bytes[7:0];
        if (v.nBytes == 3'd0) begin
            @(negedge clk_48);
            txIf.tx_valid = 1'b0;
        end else begin
            sent = 0;
            t = 0;
            while (sent < int'(v.nBytes) && t < 1000) begin
                @(negedge clk_48);
                t++;
                if (txIf.tx_strobe) begin
                    sent++;
                    if (sent < int'(v.nBytes)) txIf.tx_data = v.bytes[sent*8 +: 8];
                    else txIf.tx_valid = 1'b0;
                end
            end
            if (sent < int'(v.nBytes)) checkOutput("strobe_timeout", sent, int'(v.nBytes));
            txIf.tx_valid = 1'b0;
        end
        waitPacketEnd(startCount);
        if (pktCount == startCount && sbQ.size() > 0) void'(sbQ.pop_front());
        repeat (3) @(negedge clk_48);
    endtask

    // Runaway guard so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Main sequence: reset state, vector table, then multi-cycle corner cases.
    initial begin
        int ackLine [8] = '{1, 1, 0, 1, 1, 0, 0, 0};
        int ffLine [9]  = '{0, 0, 0, 0, 0, 1, 1, 1, 1};
        int startCount;

        vecs[0] = '{nBytes: 3'd1, bytes: 32'h000000D2, expEnClocks: 10'd76,  expStrobes: 3'd1};
        vecs[1] = '{nBytes: 3'd1, bytes: 32'h000000FF, expEnClocks: 10'd80,  expStrobes: 3'd1};
        vecs[2] = '{nBytes: 3'd4, bytes: 32'hFFFF0001, expEnClocks: 10'd180, expStrobes: 3'd4};
        vecs[3] = '{nBytes: 3'd1, bytes: 32'h000000FC, expEnClocks: 10'd80,  expStrobes: 3'd1};
        vecs[4] = '{nBytes: 3'd2, bytes: 32'h00003CA5, expEnClocks: 10'd108, expStrobes: 3'd2};
        vecs[5] = '{nBytes: 3'd0, bytes: 32'h00000000, expEnClocks: 10'd44,  expStrobes: 3'd0};

        txIf.tx_valid = 1'b0;
        txIf.tx_data  = 8'h00;
`ifdef USB_TX_ABORT_EN
        txIf.tx_abort = 1'b0;
`endif
        rst_n = 1'b0;
        repeat (3) @(negedge clk_48);
        checkOutput("reset_tx_en", int'(txIf.tx_en), 0);
        checkOutput("reset_tx_j", int'(txIf.tx_j), 1);
        checkOutput("reset_tx_se0", int'(txIf.tx_se0), 0);
        checkOutput("reset_tx_strobe", int'(txIf.tx_strobe), 0);
        checkOutput("reset_tx_busy", int'(txIf.tx_busy), 0);
        rst_n = 1'b1;
        monEnable = 1;
        repeat (2) @(negedge clk_48);

        for (int v = 0; v < 6; v++) begin
            $display("[TB] vector %0d", v);
            applyStimulus(vecs[v]);
        end

        // ACK line pattern after SYNC.
        applyStimulus(vecs[0]);
        for (int k = 0; k < 8; k++)
            checkOutput("ack_line_bit", int'(syms[8+k]), ackLine[k]);
        checkOutput("ack_first_strobe_cycle", strobeCyc[0], 28);

        // Single 0xFF: 5 holds, a stuffed toggle, 3 holds.
        applyStimulus(vecs[1]);
        for (int k = 0; k < 9; k++)
            checkOutput("ff_line_bit", int'(syms[8+k]), ffLine[k]);

        // Back-to-back bytes: fetch spacing, stretched by the stuff bit inside byte 3.
        applyStimulus(vecs[2]);
        checkOutput("b2b_strobe_gap1", strobeCyc[1] - strobeCyc[0], 32);
        checkOutput("b2b_strobe_gap2", strobeCyc[2] - strobeCyc[1], 32);
        checkOutput("b2b_strobe_gap3", strobeCyc[3] - strobeCyc[2], 36);

        // Reset during the second data byte releases the pads at once.
        ignoreNext = 1;
        startCount = pktCount;
        @(negedge clk_48);
        txIf.tx_valid = 1'b1;
        txIf.tx_data  = 8'h11;
        waitStrobe("rst_strobe1_timeout");
        txIf.tx_data = 8'h22;
        waitStrobe("rst_strobe2_timeout");
        txIf.tx_data = 8'h33;
        repeat (10) @(negedge clk_48);
        checkOutput("pre_reset_tx_en", int'(txIf.tx_en), 1);
        rst_n = 1'b0;
        txIf.tx_valid = 1'b0;
        @(negedge clk_48);
        checkOutput("midpkt_reset_tx_en", int'(txIf.tx_en), 0);
        checkOutput("midpkt_reset_tx_j", int'(txIf.tx_j), 1);
        checkOutput("midpkt_reset_tx_se0", int'(txIf.tx_se0), 0);
        checkOutput("midpkt_reset_tx_busy", int'(txIf.tx_busy), 0);
        rst_n = 1'b1;
        waitPacketEnd(startCount);
        repeat (3) @(negedge clk_48);
        applyStimulus(vecs[4]);

`ifdef USB_TX_ABORT_EN
        begin
            logic jBefore;
            int holdCyc;
            int badJ;
            int se0Cyc;
            int jCyc;
            int abortStrobes;
            int t;
            ignoreNext = 1;
            startCount = pktCount;
            @(negedge clk_48);
            txIf.tx_valid = 1'b1;
            txIf.tx_data  = 8'hA5;
            waitStrobe("abort_strobe1_timeout");
            txIf.tx_data = 8'h3C;
            waitStrobe("abort_strobe2_timeout");
            txIf.tx_data = 8'h0F;
            repeat (12) @(negedge clk_48);
            jBefore = txIf.tx_j;
            txIf.tx_abort = 1'b1;
            @(negedge clk_48);
            txIf.tx_abort = 1'b0;
            txIf.tx_valid = 1'b0;
            holdCyc = 0; badJ = 0; se0Cyc = 0; jCyc = 0; abortStrobes = 0; t = 0;
            while (txIf.tx_en && !txIf.tx_se0 && t < 200) begin
                if (txIf.tx_j != jBefore) badJ++;
                if (txIf.tx_strobe) abortStrobes++;
                holdCyc++; t++;
                @(negedge clk_48);
            end
            while (txIf.tx_en && txIf.tx_se0 && t < 200) begin
                if (txIf.tx_strobe) abortStrobes++;
                se0Cyc++; t++;
                @(negedge clk_48);
            end
            while (txIf.tx_en && !txIf.tx_se0 && t < 200) begin
                if (!txIf.tx_j) badJ++;
                if (txIf.tx_strobe) abortStrobes++;
                jCyc++; t++;
                @(negedge clk_48);
            end
            checkOutput("abort_hold_cycles", holdCyc, 7 * CPB);
            checkOutput("abort_line_level", badJ, 0);
            checkOutput("abort_se0_cycles", se0Cyc, 2 * CPB);
            checkOutput("abort_eop_j_cycles", jCyc, CPB);
            checkOutput("abort_strobes", abortStrobes, 0);
            waitPacketEnd(startCount);
            repeat (3) @(negedge clk_48);
        end
`endif

        checkOutput("stray_strobe", strayStrobe, 0);
        checkOutput("scoreboard_drained", sbQ.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
